tmds_ddio_sched: RTL and testbench

Pixel-side scheduler for the HDMI output path. Accepts one 30-bit TMDS symbol group (three 10-bit channels) per handshake and slices each symbol into five bit pairs, driving the high/low data inputs and output enable of the four-lane DDR output register: three data lanes plus the TMDS clock lane. Runs in the 5x pixel clock domain. Inserts a control-symbol preamble on start-up and control symbols on input underrun, so the serial link never stalls.

---
 rtl/tmds_ddio_sched.sv | 186 ++++++++++++++++++
 tb/tb_tmds_ddio_sched.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_ddio_sched.sv
// Purpose: slices 30-bit TMDS symbol groups into five bit pairs per lane for a 4-lane DDR output register (3 data + clock).
// Latency: pair 0 of an accepted word is on ddio_h/ddio_l one cycle after the accept edge, pair k after k+1 cycles.
// Backpressure: word_ready pulses once per 5-cycle symbol slot; a missing word_valid is filled with a control symbol.
// Optional: define TMDS_UNDERRUN_CNT_EN to add the saturating underrun_cnt output.
module tmds_ddio_sched #(
  parameter int unsigned START_WORDS = 4,
  parameter logic [9:0]  CTRL_WORD   = 10'b1101010100
) (
  input  logic        clk,
  input  logic        sclr,
  input  logic        en,
  input  logic [29:0] word_data,
  input  logic        word_valid,
  output logic        word_ready,
  output logic [3:0]  ddio_h,
  output logic [3:0]  ddio_l,
  output logic        ddio_oe,
  output logic        busy,
  output logic        underrun
`ifdef TMDS_UNDERRUN_CNT_EN
  ,
  output logic [7:0]  underrun_cnt
`else
  // no underrun counter port in this build
`endif
);

  // TMDS clock lane: five ones then five zeros, one pixel period per symbol
  localparam logic [9:0] CLK_WORD = 10'b0000011111;
  localparam logic [3:0] START_PC = 4'(START_WORDS);
  localparam logic [2:0] PH_LAST  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  typedef struct packed {
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
  } tmds_word_t;

  // lane index matches the ddio bit map: [3]=clock, [2]=R, [1]=G, [0]=B
  typedef logic [3:0][9:0] lane_set_t;

  state_t     state_q, state_d;
  logic [2:0] ph_q, ph_d;
  logic [3:0] pc_q, pc_d;
  lane_set_t  sh_q, sh_d;

  tmds_word_t word_in;
  lane_set_t  load_sym;
  lane_set_t  shift_src;
  logic [3:0] h_d, l_d;
  logic       ph_last;
  logic       preamble_done;
  logic       run_slot;
  logic       do_load;
  logic       load_data;
  logic       pair_vld;
  logic       go_sync;

  assign word_in       = word_data;
  assign ph_last       = (ph_q == PH_LAST);
  assign preamble_done = (pc_q >= START_PC);
  assign busy          = (state_q != ST_IDLE);
  // slot boundary that behaves as RUN: either already in RUN or the last preamble symbol ending
  assign run_slot      = ph_last && ((state_q == ST_RUN) ||
                                     ((state_q == ST_SYNC) && preamble_done));

  // next-state, load decision and handshake outputs
  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    pc_d       = pc_q;
    do_load    = 1'b0;
    load_data  = 1'b0;
    go_sync    = 1'b0;
    word_ready = 1'b0;
    underrun   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ph_d = 3'd0;
        if (en) begin
          state_d = ST_SYNC;
          pc_d    = 4'd1;
          do_load = 1'b1;
          go_sync = 1'b1;
        end
      end

      ST_SYNC, ST_RUN: begin
        if (!ph_last) begin
          ph_d = ph_q + 3'd1;
        end else begin
          ph_d = 3'd0;
          if (!en) begin
            // en is only honoured at a symbol boundary so the symbol always completes
            state_d = ST_IDLE;
          end else if (run_slot) begin
            state_d    = ST_RUN;
            do_load    = 1'b1;
            word_ready = 1'b1;
            load_data  = word_valid;
            underrun   = !word_valid;
          end else begin
            do_load = 1'b1;
            pc_d    = pc_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        ph_d    = 3'd0;
      end
    endcase
  end

  // symbol to load: real data or the control fill, clock lane always reloaded
  always_comb begin
    load_sym = load_data ? {CLK_WORD, word_in.r, word_in.g, word_in.b}
                         : {CLK_WORD, CTRL_WORD, CTRL_WORD, CTRL_WORD};
  end

  // next pair per lane: pair 0 straight from a fresh load, otherwise from the shifter
  always_comb begin
    shift_src = do_load ? load_sym : sh_q;
    h_d       = '0;
    l_d       = '0;
    sh_d      = '0;
    for (int i = 0; i < 4; i++) begin
      h_d[i]  = shift_src[i][0];
      l_d[i]  = shift_src[i][1];
      sh_d[i] = {2'b00, shift_src[i][9:2]};
    end
  end

  // a pair is presented whenever a symbol is loaded or one is still mid-flight
  assign pair_vld = do_load || (busy && !ph_last);

  // state, counters and registered DDR outputs
  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q <= ST_IDLE;
      ph_q    <= 3'd0;
      pc_q    <= 4'd0;
      sh_q    <= '0;
      ddio_h  <= 4'd0;
      ddio_l  <= 4'd0;
      ddio_oe <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      pc_q    <= pc_d;
      if (pair_vld) begin
        sh_q    <= sh_d;
        ddio_h  <= h_d;
        ddio_l  <= l_d;
        ddio_oe <= 1'b1;
      end else begin
        sh_q    <= '0;
        ddio_h  <= 4'd0;
        ddio_l  <= 4'd0;
        ddio_oe <= 1'b0;
      end
    end
  end

`ifdef TMDS_UNDERRUN_CNT_EN
  // saturating count of fill symbols since the last start-up
  always_ff @(posedge clk) begin
    if (sclr || go_sync) begin
      underrun_cnt <= 8'd0;
    end else if (underrun && (underrun_cnt != 8'hFF)) begin
      underrun_cnt <= underrun_cnt + 8'd1;
    end
  end
`else
  // underrun is reported only through the pulse output in this build
`endif

endmodule

// File: tb/tb_tmds_ddio_sched.sv
// Purpose: self-checking bench for tmds_ddio_sched with a symbol-stream reference model.
// Latency: model expects pair k of symbol s in cycle 5s+k+1 after the en-rise cycle.
// Backpressure: word_ready expected only at symbol boundaries after the preamble.
module tb_tmds_ddio_sched;

  localparam int         N     = 2;
  localparam logic [9:0] CTRL  = 10'b1101010100;
  localparam logic [29:0] CTRL3 = {CTRL, CTRL, CTRL};

  logic        clk = 1'b0;
  logic        sclr;
  logic        en;
  logic [29:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic [3:0]  ddio_h;
  logic [3:0]  ddio_l;
  logic        ddio_oe;
  logic        busy;
  logic        underrun;
`ifdef TMDS_UNDERRUN_CNT_EN
  logic [7:0]  underrun_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  // clock-lane pairs (h,l) = (1,1),(1,1),(1,0),(0,0),(0,0); bit k is pair k
  logic [4:0] clk_h_pat = 5'b00111;
  logic [4:0] clk_l_pat = 5'b00011;

  logic [29:0] sym_q[$];
  bit          plan_v[$];
  logic [29:0] plan_d[$];

  tmds_ddio_sched #(
    .START_WORDS(N),
    .CTRL_WORD  (CTRL)
  ) dut (
    .clk       (clk),
    .sclr      (sclr),
    .en        (en),
    .word_data (word_data),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .ddio_h    (ddio_h),
    .ddio_l    (ddio_l),
    .ddio_oe   (ddio_oe),
    .busy      (busy),
    .underrun  (underrun)
`ifdef TMDS_UNDERRUN_CNT_EN
    ,
    .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_oe"},   {31'b0, ddio_oe}, 32'd0);
    chk({tag, "_h"},    {28'b0, ddio_h},  32'd0);
    chk({tag, "_l"},    {28'b0, ddio_l},  32'd0);
    chk({tag, "_busy"}, {31'b0, busy},    32'd0);
`ifdef TMDS_UNDERRUN_CNT_EN
    chk({tag, "_cnt"},  {24'b0, underrun_cnt}, exp_cnt);
`endif
  endtask

  task automatic plan_clear();
    plan_v.delete();
    plan_d.delete();
  endtask

  task automatic plan_add(input bit v, input logic [29:0] d);
    plan_v.push_back(v);
    plan_d.push_back(d);
  endtask

  // One en-high session. Symbol j is loaded at the end of cycle 5j; symbols below N are preamble.
  // en drops from cycle stop_c on; sclr is pulsed in cycle abort_c (negative means unused).
  task automatic run(input int stop_c, input int abort_c);
    int          s, k, last_c, stop_at;
    logic [29:0] sym, d;
    logic [3:0]  eh, el;
    bit          v, slot, en_now;

    sym_q.delete();
    sym_q.push_back(CTRL3);
    last_c  = 5 * (N + plan_v.size());
    stop_at = (stop_c < 0) ? last_c : stop_c;

    en         = 1'b1;
    word_valid = 1'($urandom_range(0, 1));
    word_data  = 30'($urandom);
    #1;
    chk("start_ready",    {31'b0, word_ready}, 32'd0);
    chk("start_underrun", {31'b0, underrun},   32'd0);
    step();
    exp_cnt = 0;

    for (int c = 1; c <= last_c; c++) begin
      s   = (c - 1) / 5;
      k   = (c - 1) % 5;
      sym = sym_q[s];
      eh  = {clk_h_pat[k], sym[20 + 2*k],     sym[10 + 2*k],     sym[2*k]};
      el  = {clk_l_pat[k], sym[20 + 2*k + 1], sym[10 + 2*k + 1], sym[2*k + 1]};
      chk("oe",     {31'b0, ddio_oe}, 32'd1);
      chk("busy",   {31'b0, busy},    32'd1);
      chk("ddio_h", {28'b0, ddio_h},  {28'b0, eh});
      chk("ddio_l", {28'b0, ddio_l},  {28'b0, el});
`ifdef TMDS_UNDERRUN_CNT_EN
      chk("cnt",    {24'b0, underrun_cnt}, exp_cnt);
`endif

      slot   = (c % 5 == 0);
      en_now = (c < stop_at);
      en     = en_now;
      sclr   = (c == abort_c);

      if (slot && en_now && (c / 5 >= N)) begin
        if (plan_v.size() > 0) begin
          v = plan_v.pop_front();
          d = plan_d.pop_front();
        end else begin
          v = 1'($urandom_range(0, 1));
          d = 30'($urandom);
        end
        word_valid = v;
        word_data  = d;
        #1;
        chk("ready_slot",    {31'b0, word_ready}, 32'd1);
        chk("underrun_slot", {31'b0, underrun},   {31'b0, !v});
        sym_q.push_back(v ? d : CTRL3);
        if (!v && exp_cnt < 255) exp_cnt++;
      end else begin
        // traffic offered outside an accept slot must be ignored
        word_valid = 1'($urandom_range(0, 1));
        word_data  = 30'($urandom);
        #1;
        chk("ready_off",    {31'b0, word_ready}, 32'd0);
        chk("underrun_off", {31'b0, underrun},   32'd0);
        if (slot && en_now) sym_q.push_back(CTRL3);
      end

      if (c == abort_c) begin
        step();
        sclr    = 1'b0;
        en      = 1'b0;
        exp_cnt = 0;
        chk_idle("abort");
        return;
      end
      if (slot && !en_now) begin
        step();
        chk_idle("stop");
        return;
      end
      step();
    end
  endtask

  initial begin
    sclr       = 1'b1;
    en         = 1'b1;
    word_valid = 1'b0;
    word_data  = 30'd0;

    // reset held with en high
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle("rst");
      chk("rst_ready", {31'b0, word_ready}, 32'd0);
      chk("rst_underrun", {31'b0, underrun}, 32'd0);
    end
    sclr = 1'b0;
    en   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk_idle("idle");
      chk("idle_ready", {31'b0, word_ready}, 32'd0);
    end

    // preamble then two back-to-back directed words
    plan_clear();
    plan_add(1'b1, 30'h2AAAAAAA);
    plan_add(1'b1, 30'h15555555);
    run(-1, -1);

    // one withheld slot between two words
    plan_clear();
    plan_add(1'b1, 30'($urandom));
    plan_add(1'b0, 30'd0);
    plan_add(1'b1, 30'($urandom));
    run(-1, -1);

    // en drops at pair 1 of the first data word
    plan_clear();
    for (int i = 0; i < 3; i++) plan_add(1'b1, 30'($urandom));
    run(5 * N + 2, -1);

    // en drops during the preamble
    plan_clear();
    run(3, -1);

    // randomized stream with occasional underruns
    plan_clear();
    for (int i = 0; i < 30; i++) plan_add($urandom_range(0, 99) < 75, 30'($urandom));
    run(-1, -1);

    // sclr at pair 2 of the second data word
    plan_clear();
    for (int i = 0; i < 4; i++) plan_add($urandom_range(0, 99) < 50, 30'($urandom));
    run(-1, 5 * (N + 1) + 3);

    // recovery after the abort
    plan_clear();
    plan_add(1'b1, 30'($urandom));
    plan_add(1'b0, 30'd0);
    run(-1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
